// File: rtl/mainfsm.sv
// Main control FSM for the multicycle MIPS datapath.
// Each instruction runs through FETCH, DECODE and then its own execute, memory and
// writeback states. Every datapath control is a Moore function of the current state.
// illegal_op is registered: it pulses high for the FETCH cycle that follows a DECODE
// holding an unsupported opcode.
module mainfsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    output logic       pcwrite,
    output logic       branch,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       iord,
    output logic       memtoreg,
    output logic       regdst,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [1:0] aluop,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StMemAdr  = 4'd2,
        StMemRd   = 4'd3,
        StMemWb   = 4'd4,
        StMemWr   = 4'd5,
        StRtypeEx = 4'd6,
        StRtypeWb = 4'd7,
        StBeqEx   = 4'd8,
        StAddiEx  = 4'd9,
        StAddiWb  = 4'd10,
        StJEx     = 4'd11
    } state_e;

    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpJ     = 6'b000010;

    state_e state_q, state_d;
    logic   illegal_q, illegal_d;

    // State and illegal-opcode flag registers; reset wins over every transition.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StFetch;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    // Next-state logic; op is only looked at in DECODE and MEMADR.
    always_comb begin
        state_d   = StFetch;
        illegal_d = 1'b0;
        case (state_q)
            StFetch: state_d = StDecode;
            StDecode: begin
                case (op)
                    OpLw, OpSw: state_d = StMemAdr;
                    OpRtype:    state_d = StRtypeEx;
                    OpBeq:      state_d = StBeqEx;
                    OpAddi:     state_d = StAddiEx;
                    OpJ:        state_d = StJEx;
                    default: begin
                        state_d   = StFetch;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            StMemAdr:  state_d = (op == OpLw) ? StMemRd : StMemWr;
            StMemRd:   state_d = StMemWb;
            StRtypeEx: state_d = StRtypeWb;
            StAddiEx:  state_d = StAddiWb;
            // Terminal states and unreachable codes 12..15 all return to FETCH.
            default:   state_d = StFetch;
        endcase
    end

    // Moore output decode; anything not named for a state stays 0.
    always_comb begin
        pcwrite  = 1'b0;
        branch   = 1'b0;
        memwrite = 1'b0;
        irwrite  = 1'b0;
        regwrite = 1'b0;
        iord     = 1'b0;
        memtoreg = 1'b0;
        regdst   = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        pcsrc    = 2'b00;
        aluop    = 2'b00;
        case (state_q)
            StFetch: begin
                irwrite = 1'b1;
                pcwrite = 1'b1;
                alusrcb = 2'b01;
            end
            // Branch target is precomputed in DECODE using SignImm<<2.
            StDecode: alusrcb = 2'b11;
            StMemAdr: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            StMemRd: iord = 1'b1;
            StMemWb: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
            end
            StMemWr: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            StRtypeEx: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
            end
            StRtypeWb: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
            end
            StBeqEx: begin
                alusrca = 1'b1;
                aluop   = 2'b01;
                pcsrc   = 2'b01;
                branch  = 1'b1;
            end
            StAddiEx: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            StAddiWb: regwrite = 1'b1;
            StJEx: begin
                pcwrite = 1'b1;
                pcsrc   = 2'b10;
            end
            default: ;
        endcase
    end

    assign illegal_op = illegal_q;
    assign state      = state_q;

endmodule
